// File: rtl/boa_pmp_cfg_seq.sv
// Boot-time PMP configuration sequencer: programs pmpaddr/pmpcfg from parameter
// tables, optionally reads them back, then passes the CSR port through to the core.
module boa_pmp_cfg_seq #(
    parameter int          ENTRIES               = 4,
    parameter logic [31:0] INIT_ADDR [ENTRIES]   = '{default: 32'h0},
    parameter logic [7:0]  INIT_CFG  [ENTRIES]   = '{default: 8'h0},
    parameter bit          VERIFY                = 1'b1,
    parameter bit          AUTO_START            = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    input  logic        core_csr_we,
    input  logic [11:0] core_csr_addr,
    input  logic [31:0] core_csr_wdata,
    output logic        core_csr_present,
    output logic [31:0] core_csr_rdata,
    output logic        core_stall,
    output logic        pmp_csr_we,
    output logic [11:0] pmp_csr_addr,
    output logic [31:0] pmp_csr_wdata,
    input  logic        pmp_csr_present,
    input  logic [31:0] pmp_csr_rdata
);

    localparam int         CFG_WORDS     = (ENTRIES + 3) / 4;
    localparam logic [4:0] LAST_ADDR_IDX = 5'(ENTRIES - 1);
    localparam logic [4:0] LAST_CFG_IDX  = 5'(CFG_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_ADDR, S_WR_CFG, S_RD_ADDR, S_RD_CFG, S_DONE, S_ERROR
    } state_t;

    state_t      state_reg;
    logic [4:0]  index_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        error_reg;
    logic        auto_pending_reg;

    // Tables padded to the full 5-bit index range; unused slots read as zero.
    logic [31:0] addr_tab [32];
    logic [7:0]  cfg_byte [128];
    logic [31:0] cfg_tab  [32];

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_addr_tab
            if (gi < ENTRIES) begin : g_used
                assign addr_tab[gi] = INIT_ADDR[gi];
            end else begin : g_pad
                assign addr_tab[gi] = 32'h0;
            end
        end
        for (gi = 0; gi < 128; gi++) begin : g_cfg_byte
            if (gi < ENTRIES) begin : g_used
                assign cfg_byte[gi] = INIT_CFG[gi];
            end else begin : g_pad
                assign cfg_byte[gi] = 8'h0;
            end
        end
        for (gi = 0; gi < 32; gi++) begin : g_cfg_tab
            assign cfg_tab[gi] = {cfg_byte[4*gi+3], cfg_byte[4*gi+2],
                                  cfg_byte[4*gi+1], cfg_byte[4*gi]};
        end
    endgenerate

    logic        seq_we;
    logic [11:0] seq_addr;
    logic [31:0] seq_data;
    logic        read_bad;

    always_comb begin
        seq_we   = 1'b0;
        seq_addr = 12'h3B0 + {7'd0, index_reg};
        seq_data = addr_tab[index_reg];
        case (state_reg)
            S_WR_ADDR: seq_we = 1'b1;
            S_WR_CFG: begin
                seq_we   = 1'b1;
                seq_addr = 12'h3A0 + {7'd0, index_reg};
                seq_data = cfg_tab[index_reg];
            end
            S_RD_CFG: begin
                seq_addr = 12'h3A0 + {7'd0, index_reg};
                seq_data = cfg_tab[index_reg];
            end
            default: ;
        endcase
    end

    assign read_bad = !pmp_csr_present || (pmp_csr_rdata != seq_data);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= S_IDLE;
            index_reg        <= 5'd0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            error_reg        <= 1'b0;
            auto_pending_reg <= AUTO_START;
        end else begin
            auto_pending_reg <= 1'b0;
            case (state_reg)
                S_WR_ADDR: begin
                    if (index_reg == LAST_ADDR_IDX) begin
                        state_reg <= S_WR_CFG;
                        index_reg <= 5'd0;
                    end else begin
                        index_reg <= index_reg + 5'd1;
                    end
                end
                S_WR_CFG: begin
                    if (index_reg == LAST_CFG_IDX) begin
                        index_reg <= 5'd0;
                        if (VERIFY) begin
                            state_reg <= S_RD_ADDR;
                        end else begin
                            state_reg <= S_DONE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end
                    end else begin
                        index_reg <= index_reg + 5'd1;
                    end
                end
                S_RD_ADDR, S_RD_CFG: begin
                    if (read_bad) begin
                        // Abort on first bad read; remaining reads are skipped.
                        state_reg <= S_ERROR;
                        index_reg <= 5'd0;
                        busy_reg  <= 1'b0;
                        error_reg <= 1'b1;
                    end else if (state_reg == S_RD_ADDR && index_reg == LAST_ADDR_IDX) begin
                        state_reg <= S_RD_CFG;
                        index_reg <= 5'd0;
                    end else if (state_reg == S_RD_CFG && index_reg == LAST_CFG_IDX) begin
                        state_reg <= S_DONE;
                        index_reg <= 5'd0;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        index_reg <= index_reg + 5'd1;
                    end
                end
                default: begin
                    if (start || auto_pending_reg) begin
                        state_reg <= S_WR_ADDR;
                        index_reg <= 5'd0;
                        busy_reg  <= 1'b1;
                        done_reg  <= 1'b0;
                        error_reg <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign busy  = busy_reg;
    assign done  = done_reg;
    assign error = error_reg;

    // The core owns the PMP port whenever no sequence is running.
    assign pmp_csr_we       = busy_reg ? seq_we   : core_csr_we;
    assign pmp_csr_addr     = busy_reg ? seq_addr : core_csr_addr;
    assign pmp_csr_wdata    = busy_reg ? seq_data : core_csr_wdata;
    assign core_csr_present = busy_reg ? 1'b0     : pmp_csr_present;
    assign core_csr_rdata   = busy_reg ? 32'h0    : pmp_csr_rdata;
    assign core_stall       = busy_reg;

endmodule

// File: tb/tb_boa_pmp_cfg_seq.sv
// Bench for boa_pmp_cfg_seq: behavioural PMP CSR model, expected-access scoreboard
// and randomized core traffic / verify-fault injection.
module tb_boa_pmp_cfg_seq;

    localparam int N  = 5;
    localparam int NW = (N + 3) / 4;
    localparam int W  = N + NW;
    localparam logic [31:0] ADDR_T [N] = '{32'h0000_0003, 32'h0000_000B, 32'h1234_5678,
                                           32'hDEAD_BEEF, 32'h0000_0FFF};
    localparam logic [7:0]  CFG_T  [N] = '{8'h00, 8'h0B, 8'h1F, 8'h98, 8'h1F};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start;
    logic        busy, done, error;
    logic        core_csr_we;
    logic [11:0] core_csr_addr;
    logic [31:0] core_csr_wdata;
    logic        core_csr_present;
    logic [31:0] core_csr_rdata;
    logic        core_stall;
    logic        pmp_csr_we;
    logic [11:0] pmp_csr_addr;
    logic [31:0] pmp_csr_wdata;
    logic        pmp_csr_present;
    logic [31:0] pmp_csr_rdata;

    int checks = 0;
    int errors = 0;

    boa_pmp_cfg_seq #(
        .ENTRIES(N), .INIT_ADDR(ADDR_T), .INIT_CFG(CFG_T), .VERIFY(1'b1), .AUTO_START(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
        .core_csr_we(core_csr_we), .core_csr_addr(core_csr_addr),
        .core_csr_wdata(core_csr_wdata), .core_csr_present(core_csr_present),
        .core_csr_rdata(core_csr_rdata), .core_stall(core_stall),
        .pmp_csr_we(pmp_csr_we), .pmp_csr_addr(pmp_csr_addr), .pmp_csr_wdata(pmp_csr_wdata),
        .pmp_csr_present(pmp_csr_present), .pmp_csr_rdata(pmp_csr_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural PMP CSR file with optional read-fault injection.
    logic [31:0] mem [4096];
    bit          inj_en;
    bit          inj_absent;
    logic [11:0] inj_addr;
    logic [31:0] inj_mask;
    logic        inj_hit;

    function automatic bit claimed(input logic [11:0] a);
        return (a >= 12'h3B0 && a <= 12'h3BF) || (a >= 12'h3A0 && a <= 12'h3A3);
    endfunction

    assign inj_hit         = inj_en && !pmp_csr_we && (pmp_csr_addr == inj_addr);
    assign pmp_csr_present = claimed(pmp_csr_addr) && !(inj_hit && inj_absent);
    assign pmp_csr_rdata   = claimed(pmp_csr_addr)
                           ? (mem[pmp_csr_addr] ^ ((inj_hit && !inj_absent) ? inj_mask : 32'h0))
                           : 32'h0;

    always @(posedge clk) begin
        if (pmp_csr_we && claimed(pmp_csr_addr)) mem[pmp_csr_addr] <= pmp_csr_wdata;
    end

    typedef struct {
        bit          wr;
        logic [11:0] addr;
        logic [31:0] data;
    } ev_t;
    ev_t exp_q[$];

    function automatic ev_t mk_ev(input bit wr, input logic [11:0] a, input logic [31:0] d);
        ev_t e;
        e.wr = wr; e.addr = a; e.data = d;
        return e;
    endfunction

    // Sequence step i: pmpaddr entries first, then packed pmpcfg words.
    function automatic logic [11:0] seq_addr_of(input int i);
        if (i < N) return 12'h3B0 + 12'(i);
        return 12'h3A0 + 12'(i - N);
    endfunction

    function automatic logic [31:0] seq_data_of(input int i);
        logic [31:0] w;
        int b;
        if (i < N) return ADDR_T[i];
        w = 32'h0;
        for (int k = 0; k < 4; k++) begin
            b = 4 * (i - N) + k;
            if (b < N) w[8*k +: 8] = CFG_T[b];
        end
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every PMP-port access (core pass-through write or sequencer access).
    always @(negedge clk) begin
        ev_t e;
        if (pmp_csr_we === 1'b1 || busy === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pmp_access unexpected: we=%0b addr=%h data=%h, none expected",
                         pmp_csr_we, pmp_csr_addr, pmp_csr_wdata);
            end else begin
                e = exp_q.pop_front();
                if (pmp_csr_we !== e.wr || pmp_csr_addr !== e.addr ||
                    (e.wr && pmp_csr_wdata !== e.data)) begin
                    errors++;
                    $display("FAIL pmp_access actual we=%0b addr=%h data=%h expected we=%0b addr=%h data=%h",
                             pmp_csr_we, pmp_csr_addr, pmp_csr_wdata, e.wr, e.addr, e.data);
                end else begin
                    $display("txn %s addr=%h data=%h ok", e.wr ? "wr" : "rd", e.addr,
                             e.wr ? e.data : pmp_csr_rdata);
                end
            end
        end
    end

    task automatic idle_traffic(input int n);
        logic [11:0] a;
        bit          we;
        logic [31:0] d;
        bit          exp_p;
        logic [31:0] exp_r;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            case ($urandom_range(0, 3))
                0: a = 12'h3B0 + 12'($urandom_range(0, N - 1));
                1: a = 12'h3A0 + 12'($urandom_range(0, NW - 1));
                2: a = 12'h3B0 + 12'($urandom_range(N, 15));
                default: a = 12'($urandom);
            endcase
            we    = 1'($urandom_range(0, 1));
            d     = $urandom;
            exp_p = claimed(a);
            exp_r = exp_p ? mem[a] : 32'h0;
            core_csr_we = we; core_csr_addr = a; core_csr_wdata = d;
            if (we) exp_q.push_back(mk_ev(1'b1, a, d));
            #1;
            chk("idle_present", {31'h0, core_csr_present}, {31'h0, exp_p});
            chk("idle_rdata", core_csr_rdata, exp_r);
            chk("idle_stall", {31'h0, core_stall}, 32'h0);
        end
        @(posedge clk); #1;
        core_csr_we = 1'b0;
    endtask

    // fail_at: index of the read that is corrupted (-1: none).
    task automatic run_seq(input int fail_at, input bit core_wr, input bit dbl_start);
        int cycles;
        int exp_lat;
        int last_rd;
        logic [31:0] cv;
        cv = $urandom;
        if (core_wr) exp_q.push_back(mk_ev(1'b1, 12'h3B0, cv));
        for (int i = 0; i < W; i++) exp_q.push_back(mk_ev(1'b1, seq_addr_of(i), seq_data_of(i)));
        last_rd = (fail_at < 0) ? W - 1 : fail_at;
        for (int i = 0; i <= last_rd; i++) exp_q.push_back(mk_ev(1'b0, seq_addr_of(i), 32'h0));
        if (core_wr) exp_q.push_back(mk_ev(1'b1, 12'h3B0, cv));

        @(posedge clk); #1;
        start = 1'b1;
        if (core_wr) begin
            core_csr_we = 1'b1; core_csr_addr = 12'h3B0; core_csr_wdata = cv;
        end
        @(posedge clk); #1;
        start  = 1'b0;
        cycles = 1;
        chk("busy_after_start", {31'h0, busy}, 32'h1);
        chk("done_cleared", {31'h0, done}, 32'h0);
        chk("error_cleared", {31'h0, error}, 32'h0);
        chk("stall_busy", {31'h0, core_stall}, 32'h1);
        chk("present_busy", {31'h0, core_csr_present}, 32'h0);
        chk("rdata_busy", core_csr_rdata, 32'h0);
        while (!(done || error) && cycles < 4 * W) begin
            start = dbl_start && (cycles == 3 || cycles == 6);
            @(posedge clk); #1;
            cycles++;
        end
        start   = 1'b0;
        exp_lat = (fail_at < 0) ? 2 * W + 1 : W + 2 + fail_at;
        chk("latency", 32'(cycles), 32'(exp_lat));
        chk("done_flag", {31'h0, done}, {31'h0, fail_at < 0});
        chk("error_flag", {31'h0, error}, {31'h0, fail_at >= 0});
        chk("busy_end", {31'h0, busy}, 32'h0);
        chk("stall_end", {31'h0, core_stall}, 32'h0);
        if (core_wr) begin
            @(posedge clk); #1;
            core_csr_we = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        exp_q.delete();
    endtask

    task automatic rst_mid();
        for (int i = 0; i < N; i++) exp_q.push_back(mk_ev(1'b1, seq_addr_of(i), seq_data_of(i)));
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (N) @(posedge clk);
        #1;
        chk("in_wr_cfg_addr", {20'h0, pmp_csr_addr}, 32'h3A0);
        rst = 1'b1;
        #1;
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_no_write", {31'h0, pmp_csr_we}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("no_restart", {31'h0, busy}, 32'h0);
        chk("rst_queue", 32'(exp_q.size()), 32'h0);
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int r;
        start = 1'b0; core_csr_we = 1'b0; core_csr_addr = 12'h0; core_csr_wdata = 32'h0;
        inj_en = 1'b0; inj_absent = 1'b0; inj_addr = 12'h0; inj_mask = 32'h0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        #1 rst = 1'b1;
        #1;
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_done", {31'h0, done}, 32'h0);
        chk("reset_error", {31'h0, error}, 32'h0);
        chk("reset_stall", {31'h0, core_stall}, 32'h0);
        core_csr_we = 1'b1; core_csr_addr = 12'h3B2; core_csr_wdata = 32'hA5A5_0001;
        exp_q.push_back(mk_ev(1'b1, 12'h3B2, 32'hA5A5_0001));
        #1;
        chk("reset_pass_we", {31'h0, pmp_csr_we}, 32'h1);
        chk("reset_pass_addr", {20'h0, pmp_csr_addr}, 32'h3B2);
        chk("reset_pass_present", {31'h0, core_csr_present}, 32'h1);
        @(negedge clk); #1;
        core_csr_we = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("no_autostart", {31'h0, busy}, 32'h0);

        idle_traffic(12);
        run_seq(-1, 1'b0, 1'b0);

        inj_en = 1'b1; inj_absent = 1'b1; inj_addr = 12'h3B1;
        run_seq(1, 1'b0, 1'b0);
        inj_en = 1'b0;

        run_seq(-1, 1'b1, 1'b1);

        for (int t = 0; t < 3; t++) begin
            r          = $urandom_range(0, W - 1);
            inj_en     = 1'b1;
            inj_absent = 1'($urandom_range(0, 1));
            inj_addr   = seq_addr_of(r);
            inj_mask   = 32'h1 << $urandom_range(0, 31);
            run_seq(r, 1'($urandom_range(0, 1)), 1'b0);
            inj_en = 1'b0;
            run_seq(-1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        idle_traffic(12);
        rst_mid();
        idle_traffic(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
